// File: rtl/div_pkg.sv
// Shared definitions for the param_divider DIV/REM unit: FSM state encoding,
// default operand width and the counter-width helper.
package div_pkg;

    localparam int DIV_WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    // Ceiling log2, never less than 1 so a counter always has at least one bit.
    function automatic int clog2(input int value);
        int result;
        result = 32'sd1;
        for (int i = 32'sd1; i < 32'sd31; i++) begin
            if ((32'sd1 << i) < value) begin
                result = i + 32'sd1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring radix-2 division iteration. Purely combinational so the
// same cell can be exercised stand-alone.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    // The shifted partial remainder can reach WIDTH+1 bits, so the trial
    // subtraction is done one bit wider and its top bit is the borrow.
    logic [WIDTH:0] shifted_s;
    logic [WIDTH:0] trial_s;

    assign shifted_s = {rem, quo[WIDTH-1]};
    assign trial_s   = shifted_s - {1'b0, divisor};

    // Keep the trial difference only when it did not go negative.
    always_comb begin
        rem_next = shifted_s[WIDTH-1:0];
        quo_next = {quo[WIDTH-2:0], 1'b0};
        if (trial_s[WIDTH] == 1'b0) begin
            rem_next = trial_s[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = shifted_s[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/param_divider.sv
// Parametrised multi-cycle integer divider with Run/Ready handshake.
// One quotient bit per cycle; a zero divisor short-cuts straight to FIX.
// Optional build macro: DIVIDER_SIGNED_EN enables two's-complement mode
// (Signed_in honoured). Without it every operation is unsigned.
module param_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic             Signed_in,
    input  logic [WIDTH-1:0] Dividend_in,
    input  logic [WIDTH-1:0] Divisor_in,
    output logic [WIDTH-1:0] Quotient_out,
    output logic [WIDTH-1:0] Remainder_out,
    output logic             Ready,
    output logic             DivZero,
    output logic             Busy
);

    localparam int               CNT_W     = clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [WIDTH-1:0] ZERO_W    = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_W    = {WIDTH{1'b1}};

    div_state_e       state_r;
    div_state_e       state_nx_s;

    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] dvs_r;
    logic             zero_r;

    logic [WIDTH-1:0] rem_step_s;
    logic [WIDTH-1:0] quo_step_s;

    logic [WIDTH-1:0] dvd_mag_s;
    logic [WIDTH-1:0] dvs_mag_s;
    logic             div_zero_s;
    logic [WIDTH-1:0] res_q_s;
    logic [WIDTH-1:0] res_r_s;

    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;
    logic             ready_r;
    logic             divzero_r;
    logic             busy_r;

    assign Quotient_out  = quotient_r;
    assign Remainder_out = remainder_r;
    assign Ready         = ready_r;
    assign DivZero       = divzero_r;
    assign Busy          = busy_r;

    assign div_zero_s = (Divisor_in == ZERO_W);

`ifdef DIVIDER_SIGNED_EN
    logic dvd_neg_s;
    logic dvs_neg_s;
    logic qneg_r;
    logic rneg_r;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return (~v) + WIDTH'(1);
    endfunction

    assign dvd_neg_s = Signed_in & Dividend_in[WIDTH-1];
    assign dvs_neg_s = Signed_in & Divisor_in[WIDTH-1];

    // Convert signed operands to magnitudes; MIN stays MIN, which the
    // unsigned core then handles as 2^(WIDTH-1).
    always_comb begin
        dvd_mag_s = Dividend_in;
        dvs_mag_s = Divisor_in;
        if (dvd_neg_s) begin
            dvd_mag_s = neg_w(Dividend_in);
        end else begin
            dvd_mag_s = Dividend_in;
        end
        if (dvs_neg_s) begin
            dvs_mag_s = neg_w(Divisor_in);
        end else begin
            dvs_mag_s = Divisor_in;
        end
    end

    // Restore signs on the way out; MIN / -1 truncates to MIN naturally.
    always_comb begin
        res_q_s = quo_r;
        res_r_s = rem_r;
        if (zero_r) begin
            res_q_s = ONES_W;
            res_r_s = rem_r;
        end else begin
            res_q_s = qneg_r ? neg_w(quo_r) : quo_r;
            res_r_s = rneg_r ? neg_w(rem_r) : rem_r;
        end
    end

    // Sign flags captured together with the operands.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            qneg_r <= 1'b0;
            rneg_r <= 1'b0;
        end else if (state_r == IDLE && Run) begin
            qneg_r <= dvd_neg_s ^ dvs_neg_s;
            rneg_r <= dvd_neg_s;
        end
    end
`else
    logic unused_sign_s;

    assign unused_sign_s = Signed_in;
    assign dvd_mag_s     = Dividend_in;
    assign dvs_mag_s     = Divisor_in;

    // Unsigned-only result selection; zero divisor forces all ones.
    always_comb begin
        res_q_s = quo_r;
        res_r_s = rem_r;
        if (zero_r) begin
            res_q_s = ONES_W;
            res_r_s = rem_r;
        end else begin
            res_q_s = quo_r;
            res_r_s = rem_r;
        end
    end
`endif

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem      (rem_r),
        .quo      (quo_r),
        .divisor  (dvs_r),
        .rem_next (rem_step_s),
        .quo_next (quo_step_s)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (Run) begin
                    state_nx_s = div_zero_s ? FIX : CALC;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            CALC: begin
                if (cnt_r == CNT_ZERO) begin
                    state_nx_s = FIX;
                end else begin
                    state_nx_s = CALC;
                end
            end
            FIX: begin
                state_nx_s = DONE;
            end
            DONE: begin
                if (Run) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Operand capture and iteration datapath. On a zero divisor the raw
    // dividend is parked in rem_r so FIX can return it unnegated.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            cnt_r  <= CNT_ZERO;
            rem_r  <= ZERO_W;
            quo_r  <= ZERO_W;
            dvs_r  <= ZERO_W;
            zero_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (Run) begin
                        cnt_r  <= CNT_START;
                        rem_r  <= div_zero_s ? Dividend_in : ZERO_W;
                        quo_r  <= dvd_mag_s;
                        dvs_r  <= dvs_mag_s;
                        zero_r <= div_zero_s;
                    end
                end
                CALC: begin
                    rem_r <= rem_step_s;
                    quo_r <= quo_step_s;
                    cnt_r <= cnt_r - CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Registered outputs and handshake flags.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            quotient_r  <= ZERO_W;
            remainder_r <= ZERO_W;
            ready_r     <= 1'b0;
            divzero_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    busy_r <= Run;
                end
                FIX: begin
                    quotient_r  <= res_q_s;
                    remainder_r <= res_r_s;
                    divzero_r   <= zero_r;
                    ready_r     <= 1'b1;
                    busy_r      <= 1'b0;
                end
                DONE: begin
                    if (!Run) begin
                        ready_r   <= 1'b0;
                        divzero_r <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_param_divider.sv
// Self-checking bench for param_divider (WIDTH=32 and WIDTH=8 instances).
module tb_param_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        run, sgn;
    logic [31:0] dvd, dvs, q, r;
    logic        rdy, dz, busy;
    logic        run8, sgn8;
    logic [7:0]  dvd8, dvs8, q8, r8;
    logic        rdy8, dz8, busy8;

    always #5 clk = ~clk;

    param_divider #(.WIDTH(32)) dut (
        .clk(clk), .Reset(rst), .Run(run), .Signed_in(sgn),
        .Dividend_in(dvd), .Divisor_in(dvs),
        .Quotient_out(q), .Remainder_out(r),
        .Ready(rdy), .DivZero(dz), .Busy(busy)
    );

    param_divider #(.WIDTH(8)) dut8 (
        .clk(clk), .Reset(rst), .Run(run8), .Signed_in(sgn8),
        .Dividend_in(dvd8), .Divisor_in(dvs8),
        .Quotient_out(q8), .Remainder_out(r8),
        .Ready(rdy8), .DivZero(dz8), .Busy(busy8)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } vec_t;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[10];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        total = total + 1;
        if (act !== want) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    // Reference built on the simulator's own / and % (truncating division).
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
        exp_t   e;
        longint x, y, qq, rr;
        logic   sm;
`ifdef DIVIDER_SIGNED_EN
        sm = s;
`else
        sm = 1'b0;
`endif
        if (b == 32'd0) begin
            e.q = 32'hFFFF_FFFF; e.r = a; e.dz = 1'b1; e.lat = 2;
        end else begin
            if (sm) begin
                x = longint'($signed(a));
                y = longint'($signed(b));
            end else begin
                x = longint'({32'd0, a});
                y = longint'({32'd0, b});
            end
            qq = x / y;
            rr = x % y;
            e.q = qq[31:0]; e.r = rr[31:0]; e.dz = 1'b0; e.lat = 34;
        end
        return e;
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input exp_t e, input string tag);
        int   n;
        logic overlap;
        exp_t got;
        sb_q.push_back(e);
        run = 1'b1; dvd = a; dvs = b; sgn = s;
        @(posedge clk); #1;
        n = 1;
        chk({tag, "_busy_after_accept"}, busy, 1'b1);
        chk({tag, "_ready_after_accept"}, rdy, 1'b0);
        dvd = $urandom; dvs = $urandom; sgn = ~s;
        overlap = 1'b0;
        while (!rdy && n < 200) begin
            @(posedge clk); #1;
            n = n + 1;
            if (busy && rdy) overlap = 1'b1;
        end
        if (sb_q.size() == 0) begin
            chk({tag, "_scoreboard_empty"}, 64'd1, 64'd0);
        end else begin
            got = sb_q.pop_front();
            chk({tag, "_latency"}, n, got.lat);
            chk({tag, "_quotient"}, q, got.q);
            chk({tag, "_remainder"}, r, got.r);
            chk({tag, "_divzero"}, dz, got.dz);
            chk({tag, "_busy_ready_overlap"}, overlap, 1'b0);
            @(posedge clk); #1;
            chk({tag, "_hold_ready"}, rdy, 1'b1);
            chk({tag, "_hold_quotient"}, q, got.q);
            run = 1'b0;
            @(posedge clk); #1;
            chk({tag, "_ready_drop"}, rdy, 1'b0);
            chk({tag, "_divzero_drop"}, dz, 1'b0);
            chk({tag, "_quotient_kept"}, q, got.q);
            chk({tag, "_remainder_kept"}, r, got.r);
        end
    endtask

    initial begin
        exp_t        e;
        logic [31:0] a, b;
        logic        s;
        int          n;

        rst = 1'b1; run = 1'b0; sgn = 1'b0; dvd = 32'd0; dvs = 32'd0;
        run8 = 1'b0; sgn8 = 1'b0; dvd8 = 8'd0; dvs8 = 8'd0;

        vecs[0] = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0};
        vecs[1] = '{32'h0000_1234,  32'd0,          1'b0, 32'hFFFF_FFFF,  32'h0000_1234,  1'b1};
`ifdef DIVIDER_SIGNED_EN
        vecs[2] = '{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
        vecs[3] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          1'b0};
        vecs[4] = '{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          1'b0};
`else
        vecs[2] = '{32'hFFFF_FFF9,  32'd2,          1'b1, 32'h7FFF_FFFC,  32'd1,          1'b0};
        vecs[3] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'd0,          32'h8000_0000,  1'b0};
        vecs[4] = '{32'd7,          32'hFFFF_FFFE,  1'b1, 32'd0,          32'd7,          1'b0};
`endif
        vecs[5] = '{32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0,          1'b0};
        vecs[6] = '{32'd5,          32'd9,          1'b0, 32'd0,          32'd5,          1'b0};
        vecs[7] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 32'd1,          32'd0,          1'b0};
        vecs[8] = '{32'h8000_0000,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'h8000_0000,  1'b1};
        vecs[9] = '{32'hDEAD_BEEF,  32'h0000_1000,  1'b0, 32'h000D_EADB,  32'h0000_0EEF,  1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_quotient", q, 32'd0);
        chk("reset_remainder", r, 32'd0);
        chk("reset_ready", rdy, 1'b0);
        chk("reset_divzero", dz, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_ready8", rdy8, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            e.q = vecs[i].q; e.r = vecs[i].r; e.dz = vecs[i].dz;
            e.lat = vecs[i].dz ? 2 : 34;
            run_op(vecs[i].a, vecs[i].b, vecs[i].s, e, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 16; i++) begin
            a = $urandom;
            b = (i % 4 == 0) ? 32'($urandom_range(1, 15)) : $urandom;
            if (i == 5) b = 32'd0;
            if (i == 7) b = 32'hFFFF_FFFF;
            s = 1'($urandom_range(0, 1));
            run_op(a, b, s, model(a, b, s), $sformatf("rnd%0d", i));
        end

        // Leave known non-zero results, then reset during the 10th iteration.
        e = '{32'd14, 32'd2, 1'b0, 34};
        run_op(32'd100, 32'd7, 1'b0, e, "pre_reset");
        run = 1'b1; dvd = 32'hFFFF_FFFF; dvs = 32'd3; sgn = 1'b0;
        @(posedge clk); #1;
        repeat (9) @(posedge clk);
        #1;
        chk("mid_calc_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("midreset_quotient", q, 32'd0);
        chk("midreset_remainder", r, 32'd0);
        chk("midreset_ready", rdy, 1'b0);
        chk("midreset_busy", busy, 1'b0);
        chk("midreset_divzero", dz, 1'b0);
        run = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        e = '{32'h0FFF_FFFF, 32'h0000_000F, 1'b0, 34};
        run_op(32'hFFFF_FFFF, 32'h10, 1'b0, e, "post_reset");

        // WIDTH=8: 200/13 with Run held high in DONE.
        run8 = 1'b1; dvd8 = 8'd200; dvs8 = 8'd13; sgn8 = 1'b0;
        @(posedge clk); #1;
        n = 1;
        dvd8 = 8'd3; dvs8 = 8'd1;
        while (!rdy8 && n < 100) begin
            @(posedge clk); #1;
            n = n + 1;
        end
        chk("w8_latency", n, 10);
        chk("w8_quotient", q8, 8'd15);
        chk("w8_remainder", r8, 8'd5);
        chk("w8_divzero", dz8, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk($sformatf("w8_hold_ready%0d", k), rdy8, 1'b1);
            chk($sformatf("w8_hold_quotient%0d", k), q8, 8'd15);
            chk($sformatf("w8_hold_remainder%0d", k), r8, 8'd5);
        end
        run8 = 1'b0;
        @(posedge clk); #1;
        chk("w8_ready_drop", rdy8, 1'b0);
        chk("w8_quotient_kept", q8, 8'd15);

        chk("scoreboard_drained", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
